// File: rtl/enable_sw_decoder.sv
// Stability filter and one-hot encoder for the Enable_SW bus, with change
// counting and a 4-digit multiplexed seven-segment readout.
module enable_sw_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int SCAN_DIV      = 50000
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [3:0] Enable_SW,
    output logic [1:0] Func_Sel,
    output logic       Sel_Valid,
    output logic       Sel_Change,
    output logic       Err,
    output logic [7:0] Chg_Count,
    output logic [6:0] Seg,
    output logic [3:0] An
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_PRE  = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [6:0] GLYPH_F    = 7'b0001110;
    localparam logic [6:0] GLYPH_E    = 7'b0000110;
    localparam logic [6:0] GLYPH_DASH = 7'b0111111;

    logic [3:0]        r_sw_q;
    logic [STAB_W-1:0] r_stab_cnt;
    logic [1:0]        r_func_sel;
    logic              r_sel_valid;
    logic              r_sel_change;
    logic              r_err;
    logic [7:0]        r_chg_count;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic [1:0]        r_dig;

    logic              w_same;
    logic              w_accept;
    logic [1:0]        w_index;
    logic [6:0]        w_seg;
    logic [3:0]        w_an;

    function automatic logic f_is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] f_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [6:0] f_hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b0111111;
        endcase
        return g;
    endfunction

    // Acceptance fires only on the step into saturation, so a held value is taken once.
    assign w_same   = (Enable_SW == r_sw_q);
    assign w_accept = w_same && (r_stab_cnt == STAB_PRE);
    assign w_index  = f_index(r_sw_q);

    // Input filter, selection state and change counter.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_sw_q       <= 4'd0;
            r_stab_cnt   <= '0;
            r_func_sel   <= 2'd0;
            r_sel_valid  <= 1'b0;
            r_sel_change <= 1'b0;
            r_err        <= 1'b0;
            r_chg_count  <= 8'd0;
        end else begin
            r_sw_q       <= Enable_SW;
            r_sel_change <= 1'b0;
            if (!w_same) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != STAB_MAX) begin
                r_stab_cnt <= r_stab_cnt + STAB_W'(1);
            end else begin
                r_stab_cnt <= r_stab_cnt;
            end
            if (w_accept) begin
                if (f_is_onehot(r_sw_q)) begin
                    r_func_sel  <= w_index;
                    r_sel_valid <= 1'b1;
                    r_err       <= 1'b0;
                    if ((w_index != r_func_sel) || !r_sel_valid) begin
                        r_sel_change <= 1'b1;
                        r_chg_count  <= r_chg_count + 8'd1;
                    end
                end else if (r_sw_q == 4'd0) begin
                    r_sel_valid <= 1'b0;
                    r_err       <= 1'b0;
                end else begin
                    r_sel_valid <= 1'b0;
                    r_err       <= 1'b1;
                end
            end
        end
    end

    // Digit slot timer and digit index.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_dig      <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_dig      <= r_dig + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Segment and anode decode straight from registered state, so no extra lag.
    always_comb begin
        w_seg = GLYPH_DASH;
        w_an  = 4'b1110;
        case (r_dig)
            2'd0: begin
                w_an = 4'b1110;
                if (r_err) begin
                    w_seg = GLYPH_E;
                end else if (!r_sel_valid) begin
                    w_seg = GLYPH_DASH;
                end else begin
                    w_seg = f_hex_glyph({2'b00, r_func_sel} + 4'd1);
                end
            end
            2'd1: begin
                w_an  = 4'b1101;
                w_seg = GLYPH_F;
            end
            2'd2: begin
                w_an  = 4'b1011;
                w_seg = f_hex_glyph(r_chg_count[3:0]);
            end
            2'd3: begin
                w_an  = 4'b0111;
                w_seg = f_hex_glyph(r_chg_count[7:4]);
            end
            default: begin
                w_an  = 4'b1110;
                w_seg = GLYPH_DASH;
            end
        endcase
    end

    assign Func_Sel   = r_func_sel;
    assign Sel_Valid  = r_sel_valid;
    assign Sel_Change = r_sel_change;
    assign Err        = r_err;
    assign Chg_Count  = r_chg_count;
    assign Seg        = w_seg;
    assign An         = w_an;

endmodule

// File: tb/tb_enable_sw_decoder.sv
// Directed bench for enable_sw_decoder with STABLE_CYCLES=4, SCAN_DIV=4.
module tb_enable_sw_decoder;

    logic       sysclk = 1'b0;
    logic       reset;
    logic [3:0] Enable_SW;
    logic [1:0] Func_Sel;
    logic       Sel_Valid;
    logic       Sel_Change;
    logic       Err;
    logic [7:0] Chg_Count;
    logic [6:0] Seg;
    logic [3:0] An;

    int checks = 0;
    int errors = 0;
    int pulse_total = 0;

    enable_sw_decoder #(.STABLE_CYCLES(4), .SCAN_DIV(4)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .Enable_SW (Enable_SW),
        .Func_Sel  (Func_Sel),
        .Sel_Valid (Sel_Valid),
        .Sel_Change(Sel_Change),
        .Err       (Err),
        .Chg_Count (Chg_Count),
        .Seg       (Seg),
        .An        (An)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (Sel_Change === 1'b1) pulse_total++;
    end

    typedef struct {
        logic [3:0] sw;
        int         cycles;
        logic [1:0] sel;
        logic       valid;
        logic       err;
        logic [7:0] cnt;
        int         pulses;
        logic [6:0] seg0;
    } vec_t;

    vec_t tbl [0:11];

    localparam logic [6:0] G_DASH = 7'b0111111;
    localparam logic [6:0] G_E    = 7'b0000110;
    localparam logic [6:0] G_1    = 7'b1111001;
    localparam logic [6:0] G_3    = 7'b0110000;
    localparam logic [6:0] G_4    = 7'b0011001;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] v);
        int n;
        n = 0;
        while (An !== v && n < 40) begin
            tick();
            n++;
        end
        if (An !== v) begin
            checks++;
            errors++;
            $display("FAIL wait_an timeout actual=%b expected=%b", An, v);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        int p0;
        for (int i = lo; i <= hi; i++) begin
            p0 = pulse_total;
            Enable_SW = tbl[i].sw;
            repeat (tbl[i].cycles) tick();
            chk($sformatf("row%0d func_sel", i), Func_Sel, tbl[i].sel);
            chk($sformatf("row%0d sel_valid", i), Sel_Valid, tbl[i].valid);
            chk($sformatf("row%0d err", i), Err, tbl[i].err);
            chk($sformatf("row%0d chg_count", i), Chg_Count, tbl[i].cnt);
            chk($sformatf("row%0d pulses", i), pulse_total - p0, tbl[i].pulses);
            if (tbl[i].cycles >= 7) begin
                wait_an(4'b1110);
                chk($sformatf("row%0d seg0", i), Seg, tbl[i].seg0);
            end
        end
    endtask

    task automatic accept(input logic [3:0] sw);
        Enable_SW = sw;
        repeat (7) tick();
    endtask

    logic [7:0] exp_cnt;
    logic       toggle;
    logic       wrapped;
    int         guard;
    logic [3:0] an_exp [0:3];
    logic [6:0] seg_exp [0:3];

    initial begin
        //             sw       cyc sel  v     e     cnt    p  seg0
        tbl[0]  = '{4'b0100, 3, 2'd0, 1'b1, 1'b0, 8'd1, 0, G_1};
        tbl[1]  = '{4'b0001, 7, 2'd0, 1'b1, 1'b0, 8'd1, 0, G_1};
        tbl[2]  = '{4'b0011, 7, 2'd2, 1'b0, 1'b1, 8'd2, 0, G_E};
        tbl[3]  = '{4'b0000, 7, 2'd2, 1'b0, 1'b0, 8'd2, 0, G_DASH};
        tbl[4]  = '{4'b0100, 7, 2'd2, 1'b1, 1'b0, 8'd3, 1, G_3};
        tbl[5]  = '{4'b1000, 7, 2'd3, 1'b1, 1'b0, 8'd4, 1, G_4};
        tbl[6]  = '{4'b1111, 7, 2'd3, 1'b0, 1'b1, 8'd4, 0, G_E};
        tbl[7]  = '{4'b1000, 7, 2'd3, 1'b1, 1'b0, 8'd5, 1, G_4};
        tbl[8]  = '{4'b0010, 4, 2'd3, 1'b1, 1'b0, 8'd5, 0, G_4};
        tbl[9]  = '{4'b0001, 7, 2'd0, 1'b1, 1'b0, 8'd6, 1, G_1};
        tbl[10] = '{4'b0000, 7, 2'd0, 1'b0, 1'b0, 8'd6, 0, G_DASH};
        tbl[11] = '{4'b0001, 7, 2'd0, 1'b1, 1'b0, 8'd7, 1, G_1};

        // Reset values, visible without any clock edge.
        reset = 1'b1;
        Enable_SW = 4'b0000;
        #1;
        chk("rst func_sel", Func_Sel, 2'd0);
        chk("rst flags", {Sel_Valid, Sel_Change, Err}, 3'b000);
        chk("rst chg_count", Chg_Count, 8'd0);
        chk("rst an", An, 4'b1110);
        chk("rst seg", Seg, G_DASH);
        repeat (2) @(posedge sysclk);
        #2;
        reset = 1'b0;
        Enable_SW = 4'b0001;

        // Steady 0001 from edge 1 is accepted at edge 5.
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("lat edge%0d valid/change", e), {Sel_Valid, Sel_Change}, 2'b00);
        end
        tick();
        chk("lat edge5 func_sel", Func_Sel, 2'd0);
        chk("lat edge5 valid/change", {Sel_Valid, Sel_Change}, 2'b11);
        chk("lat edge5 chg_count", Chg_Count, 8'd1);
        tick();
        chk("lat edge6 change", Sel_Change, 1'b0);

        run_rows(0, 1);

        // 0100 held: pulse exactly 4 edges after the first sampling edge.
        Enable_SW = 4'b0100;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk($sformatf("hold edge%0d change", e), Sel_Change, 1'b0);
            chk($sformatf("hold edge%0d func_sel", e), Func_Sel, 2'd0);
        end
        tick();
        chk("hold edge5 change", Sel_Change, 1'b1);
        chk("hold edge5 func_sel", Func_Sel, 2'd2);
        chk("hold edge5 chg_count", Chg_Count, 8'd2);
        tick();
        chk("hold edge6 change", Sel_Change, 1'b0);

        run_rows(2, 11);

        // Counter wrap through 256 alternating acceptances.
        exp_cnt = 8'd7;
        toggle  = 1'b0;
        wrapped = 1'b0;
        for (int i = 0; i < 256; i++) begin
            accept(toggle ? 4'b0001 : 4'b0010);
            toggle = ~toggle;
            if (exp_cnt == 8'd255) wrapped = 1'b1;
            exp_cnt = exp_cnt + 8'd1;
            chk($sformatf("wrap%0d chg_count", i), Chg_Count, exp_cnt);
            chk($sformatf("wrap%0d valid", i), Sel_Valid, 1'b1);
        end
        chk("wrap seen", wrapped, 1'b1);
        guard = 0;
        while (exp_cnt != 8'h29 && guard < 300) begin
            accept(toggle ? 4'b0001 : 4'b0010);
            toggle = ~toggle;
            exp_cnt = exp_cnt + 8'd1;
            guard++;
        end
        accept(4'b1000);
        chk("pre-scan func_sel", Func_Sel, 2'd3);
        chk("pre-scan chg_count", Chg_Count, 8'h2A);

        // Display scan over one full refresh.
        an_exp[0] = 4'b1110; seg_exp[0] = G_4;
        an_exp[1] = 4'b1101; seg_exp[1] = 7'b0001110;
        an_exp[2] = 4'b1011; seg_exp[2] = 7'b0001000;
        an_exp[3] = 4'b0111; seg_exp[3] = 7'b0100100;
        wait_an(4'b1101);
        wait_an(4'b1110);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("scan%0d an", k), An, an_exp[k / 4]);
            chk($sformatf("scan%0d seg", k), Seg, seg_exp[k / 4]);
            tick();
        end

        // Asynchronous reset mid-window and mid-slot.
        Enable_SW = 4'b0100;
        repeat (2) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst func_sel", Func_Sel, 2'd0);
        chk("arst flags", {Sel_Valid, Sel_Change, Err}, 3'b000);
        chk("arst chg_count", Chg_Count, 8'd0);
        chk("arst an", An, 4'b1110);
        chk("arst seg", Seg, G_DASH);
        tick();
        #2;
        reset = 1'b0;
        repeat (4) tick();
        chk("post-rst edge4 valid", Sel_Valid, 1'b0);
        tick();
        chk("post-rst edge5 valid/change", {Sel_Valid, Sel_Change}, 2'b11);
        chk("post-rst edge5 func_sel", Func_Sel, 2'd2);
        chk("post-rst edge5 chg_count", Chg_Count, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
